// File: rtl/ysyx_25040111_mem_arbiter.sv
// rtl/ysyx_25040111_mem_arbiter.sv - I/D arbiter with registered grant FSM for the shared LSU port
// Optional watchdog: define YSYX_25040111_ARB_TIMEOUT_EN.
module ysyx_25040111_mem_arbiter #(
  parameter int PRIO_D  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [7:0]  i_tlen,
  output logic        i_ok,
  output logic        i_last,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic        d_ren,
  input  logic        d_sign,
  input  logic [1:0]  d_mask,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ok,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        m_start,
  output logic        m_wen,
  output logic        m_ren,
  output logic        m_sign,
  output logic [1:0]  m_mask,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [7:0]  m_tlen,
  input  logic        m_ok,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t      state, state_next;
  logic        last_d;
  logic [7:0]  beat_cnt;
  logic        grant_i, grant_d;
  logic        tmo;

`ifdef YSYX_25040111_ARB_TIMEOUT_EN
  // wd holds the number of granted cycles since m_start or the last m_ok
  logic [15:0] wd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                wd <= 16'd0;
    else if (state == IDLE)   wd <= 16'd0;
    else if (m_start || m_ok) wd <= 16'd1;
    else                      wd <= wd + 16'd1;
  end

  assign tmo = (state != IDLE) && !m_ok && (wd == 16'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          if (PRIO_D != 0 || !last_d) grant_d = 1'b1;
          else                        grant_i = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i) state_next = GNT_I;
        if (grant_d) state_next = GNT_D;
      end
      GNT_I: if (tmo || (m_ok && beat_cnt == 8'd0)) state_next = IDLE;
      GNT_D: if (tmo || m_ok) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign i_ok    = (state == GNT_I) && (m_ok || tmo);
  assign d_ok    = (state == GNT_D) && (m_ok || tmo);
  assign i_last  = i_ok && (beat_cnt == 8'd0 || tmo);
  assign err     = tmo;
  assign i_rdata = (state == GNT_I && m_ok) ? m_rdata : 32'd0;
  assign d_rdata = (state == GNT_D && m_ok) ? m_rdata : 32'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      beat_cnt <= 8'd0;
      m_start  <= 1'b0;
      m_wen    <= 1'b0;
      m_ren    <= 1'b0;
      m_sign   <= 1'b0;
      m_mask   <= 2'b00;
      m_addr   <= 32'd0;
      m_wdata  <= 32'd0;
      m_tlen   <= 8'd0;
    end else begin
      state   <= state_next;
      m_start <= grant_i | grant_d;
      if (state == GNT_I && state_next == IDLE) last_d <= 1'b0;
      if (state == GNT_D && state_next == IDLE) last_d <= 1'b1;
      if (grant_i) begin
        m_wen    <= 1'b0;
        m_ren    <= 1'b1;
        m_sign   <= 1'b0;
        m_mask   <= 2'b11;
        m_addr   <= i_addr;
        m_wdata  <= 32'd0;
        m_tlen   <= i_tlen;
        beat_cnt <= i_tlen;
      end else if (grant_d) begin
        m_wen    <= d_wen;
        m_ren    <= d_ren;
        m_sign   <= d_sign;
        m_mask   <= d_mask;
        m_addr   <= d_addr;
        m_wdata  <= d_wdata;
        m_tlen   <= 8'd0;
        beat_cnt <= 8'd0;
      end else if (state == GNT_I && m_ok && beat_cnt != 8'd0) begin
        beat_cnt <= beat_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// tb/tb_ysyx_25040111_mem_arbiter.sv - directed bench: fixed-priority and round-robin instances
module tb_ysyx_25040111_mem_arbiter;

  logic        clock, reset;
  logic        i_req, d_req, d_wen, d_ren, d_sign, m_ok;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [7:0]  i_tlen;
  logic [1:0]  d_mask;

  logic        i_ok, i_last, d_ok, err, m_start, m_wen, m_ren, m_sign;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_mask;
  logic [7:0]  m_tlen;

  logic        r_i_ok, r_i_last, r_d_ok, r_err, r_m_start, r_m_wen, r_m_ren, r_m_sign;
  logic [31:0] r_i_rdata, r_d_rdata, r_m_addr, r_m_wdata;
  logic [1:0]  r_m_mask;
  logic [7:0]  r_m_tlen;

  int nvec = 0;
  int nbad = 0;

  ysyx_25040111_mem_arbiter #(.PRIO_D(1), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_tlen(i_tlen),
    .i_ok(i_ok), .i_last(i_last), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_ren(d_ren), .d_sign(d_sign), .d_mask(d_mask),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ok(d_ok), .d_rdata(d_rdata), .err(err),
    .m_start(m_start), .m_wen(m_wen), .m_ren(m_ren), .m_sign(m_sign), .m_mask(m_mask),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_tlen(m_tlen), .m_ok(m_ok), .m_rdata(m_rdata)
  );

  ysyx_25040111_mem_arbiter #(.PRIO_D(0), .TIMEOUT(8)) dut_rr (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_tlen(i_tlen),
    .i_ok(r_i_ok), .i_last(r_i_last), .i_rdata(r_i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_ren(d_ren), .d_sign(d_sign), .d_mask(d_mask),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ok(r_d_ok), .d_rdata(r_d_rdata), .err(r_err),
    .m_start(r_m_start), .m_wen(r_m_wen), .m_ren(r_m_ren), .m_sign(r_m_sign), .m_mask(r_m_mask),
    .m_addr(r_m_addr), .m_wdata(r_m_wdata), .m_tlen(r_m_tlen), .m_ok(m_ok), .m_rdata(m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dut"}, 32'({i_ok, i_last, d_ok, err, m_start, m_wen, m_ren, m_sign, m_mask, m_tlen})
          | i_rdata | d_rdata | m_addr | m_wdata, 32'd0);
    check({tag, "_rr"}, 32'({r_i_ok, r_i_last, r_d_ok, r_err, r_m_start, r_m_wen, r_m_ren, r_m_sign,
          r_m_mask, r_m_tlen}) | r_i_rdata | r_d_rdata | r_m_addr | r_m_wdata, 32'd0);
  endtask

  // Already granted I burst: one m_ok per beat with an idle cycle between beats
  task automatic i_burst(input int beats);
    for (int b = 0; b < beats; b++) begin
      tick();
      m_ok = 1'b1;
      m_rdata = 32'(32'hA0 + b);
      #1;
      check("i_ok", 32'(i_ok), 32'd1);
      check("i_rdata", i_rdata, 32'(32'hA0 + b));
      check("i_last", 32'(i_last), 32'(b == beats - 1));
      check("m_tlen", 32'(m_tlen), 32'(beats - 1));
      check("i_burst_d_ok", 32'(d_ok), 32'd0);
      tick();
      m_ok = 1'b0;
      if (b == beats - 1) i_req = 1'b0;
      #1;
      check("i_ok_gap", 32'(i_ok), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; i_req = 0; d_req = 0; d_wen = 0; d_ren = 0; d_sign = 0; m_ok = 0;
    i_addr = 0; i_tlen = 0; d_mask = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;

    // single D load
    d_req = 1; d_ren = 1; d_mask = 2'b10; d_addr = 32'h8000_0010;
    tick();
    check("d_m_start", 32'(m_start), 32'd1);
    check("d_m_addr", m_addr, 32'h8000_0010);
    check("d_m_ren_wen", 32'({m_ren, m_wen, m_mask}), 32'b1010);
    check("d_m_tlen", 32'(m_tlen), 32'd0);
    tick();
    check("d_m_start_pulse", 32'(m_start), 32'd0);
    tick();
    tick();
    m_ok = 1; m_rdata = 32'h1234_5678;
    #1;
    check("d_ok", 32'(d_ok), 32'd1);
    check("d_rdata", d_rdata, 32'h1234_5678);
    check("d_i_ok", 32'(i_ok), 32'd0);
    check("d_err", 32'(err), 32'd0);
    tick();
    d_req = 0; m_ok = 0; d_ren = 0;
    #1;
    check("d_ok_done", 32'(d_ok), 32'd0);
    tick();
    check("idle_no_start", 32'(m_start), 32'd0);
    m_ok = 1; m_rdata = 32'hFFFF_FFFF;
    #1;
    check("idle_m_ok_ign", 32'({i_ok, d_ok}), 32'd0);
    m_ok = 0;

    // I burst of 4 beats
    i_req = 1; i_addr = 32'h3000_0000; i_tlen = 8'd3;
    tick();
    check("i_m_start", 32'(m_start), 32'd1);
    check("i_m_addr", m_addr, 32'h3000_0000);
    check("i_m_fields", 32'({m_wen, m_ren, m_sign, m_mask}), 32'b01011);
    i_burst(4);

    // simultaneous requests, D wins, I granted right after
    i_req = 1; i_addr = 32'h0000_0040; i_tlen = 8'd0;
    d_req = 1; d_wen = 1; d_ren = 0; d_mask = 2'b01; d_addr = 32'h0000_0050; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("prio_m_start", 32'(m_start), 32'd1);
    check("prio_d_addr", m_addr, 32'h0000_0050);
    check("prio_d_wdata", m_wdata, 32'hDEAD_BEEF);
    check("prio_d_wen", 32'({m_wen, m_ren, m_mask}), 32'b1001);
    tick();
    m_ok = 1;
    #1;
    check("prio_d_ok", 32'({d_ok, i_ok}), 32'b10);
    tick();
    d_req = 0; d_wen = 0; m_ok = 0;
    tick();
    check("prio_i_start", 32'(m_start), 32'd1);
    check("prio_i_addr", m_addr, 32'h0000_0040);
    tick();
    m_ok = 1; m_rdata = 32'h55;
    #1;
    check("prio_i_ok_last", 32'({i_ok, i_last, d_ok}), 32'b110);
    tick();
    i_req = 0; m_ok = 0;

    // round-robin instance, both requests held
    reset = 1;
    tick();
    i_req = 1; i_addr = 32'h0000_1000; i_tlen = 8'd0;
    d_req = 1; d_ren = 1; d_addr = 32'h0000_2000;
    reset = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_start", 32'(r_m_start), 32'd1);
      check("rr_addr", r_m_addr, (k % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000);
      tick();
      m_ok = 1;
      #1;
      check("rr_ok", 32'({r_d_ok, r_i_ok}), (k % 2 == 0) ? 32'b10 : 32'b01);
      tick();
      m_ok = 0;
    end
    i_req = 0; d_req = 0; d_ren = 0;

    // reset in the middle of a burst, then a full restart
    reset = 1;
    tick();
    reset = 0;
    i_req = 1; i_addr = 32'h3000_0100; i_tlen = 8'd3;
    tick();
    check("rst_i_start", 32'(m_start), 32'd1);
    tick();
    m_ok = 1;
    #1;
    check("rst_beat0", 32'({i_ok, i_last}), 32'b10);
    tick();
    m_ok = 1;
    reset = 1;
    #1;
    check_all_zero("mid_reset");
    tick();
    reset = 0; m_ok = 0;
    tick();
    check("restart_start", 32'(m_start), 32'd1);
    check("restart_tlen", 32'(m_tlen), 32'd3);
    i_burst(4);

`ifdef YSYX_25040111_ARB_TIMEOUT_EN
    d_req = 1; d_ren = 1; d_addr = 32'h0000_3000; m_rdata = 32'hCAFE_F00D;
    tick();
    check("tmo_start", 32'(m_start), 32'd1);
    for (int c = 1; c < 8; c++) begin
      tick();
      check("tmo_wait", 32'({d_ok, err}), 32'd0);
    end
    tick();
    check("tmo_ok_err", 32'({d_ok, err}), 32'b11);
    check("tmo_rdata", d_rdata, 32'd0);
    tick();
    d_req = 0; m_ok = 1;
    #1;
    check("tmo_late_ok", 32'({d_ok, err}), 32'd0);
    m_ok = 0;
`else
    check("err_tied", 32'(err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
